imem_fetch_ctrl: RTL

Sequencer that sits between the fetch stage and a 64-bit-wide instruction memory and assembles one Y86-64 instruction (1–10 bytes) per request from one to three aligned word reads. It decodes the icode in byte 0 to decide how many further words are needed, so short instructions complete early. It range-checks every word address and reports memory errors to the fetch stage, which uses them for its status. It honours a redirect abort from the pipeline at any point.

---
 rtl/y86_pkg.sv | 53 +++++
 rtl/fetch_len_decode.sv | 12 +
 rtl/imem_fetch_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes,
// instruction length rule and fetch sequencer states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RESP,
    S_DRAIN
  } fetch_state_t;

  // Unknown icodes count as one byte; fetch flags them as SINS.
  function automatic logic [3:0] instr_len(
    input logic [3:0] icode
  );
    logic [3:0] len;
    len = 4'd1;
    unique case (1'b1)
      (icode == IRRMOVQ),
      (icode == IOPQ),
      (icode == IPUSHQ),
      (icode == IPOPQ):   len = 4'd2;
      (icode == IJXX),
      (icode == ICALL):   len = 4'd9;
      (icode == IIRMOVQ),
      (icode == IRMMOVQ),
      (icode == IMRMOVQ): len = 4'd10;
      default:            len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Instruction length from icode; shared with the
// fetch stage for valP.
module fetch_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len
);

  assign len = instr_len(icode);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Assembles one Y86-64 instruction from up to three
// aligned 64-bit instruction memory reads.
module imem_fetch_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [63:0] f_pc,
  input  logic        f_abort,
  output logic        f_ready,
  output logic        f_valid,
  output logic [79:0] f_instr,
  output logic        f_imem_error,
  output logic        m_req,
  output logic [63:0] m_addr,
  input  logic        m_ack,
  input  logic [63:0] m_rdata
);

  localparam logic [63:0] LAST_WORD =
    64'(IMEM_SIZE - 8);

  fetch_state_t state, state_n;

  logic [2:0]   off_q;
  logic [3:0]   len_q;
  logic [1:0]   nw_q;
  logic         err_q, err_n;
  logic [63:0]  addr_q, addr_n;
  logic [63:0]  w0_q, w1_q;
  logic [7:0]   w2_q;

  logic         accept;
  logic         ld0, ld1, ld2;
  logic [63:0]  base;
  logic [63:0]  addr_inc;
  logic         base_oob;
  logic         inc_oob;
  logic [3:0]   icode;
  logic [3:0]   len_d;
  logic [1:0]   nw_d;
  logic [135:0] win_buf;
  logic [79:0]  win;

  assign base     = {f_pc[63:3], 3'b000};
  assign addr_inc = addr_q + 64'd8;
  assign base_oob = base > LAST_WORD;
  assign inc_oob  = addr_inc > LAST_WORD;
  assign icode    = m_rdata[{off_q, 3'b100} +: 4];

  fetch_len_decode u_len (
    .icode (icode),
    .len   (len_d)
  );

  assign nw_d = 2'((5'(off_q) + 5'(len_d) + 5'd7) >> 3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    err_n   = err_q;
    accept  = 1'b0;
    ld0     = 1'b0;
    ld1     = 1'b0;
    ld2     = 1'b0;
    f_ready = 1'b0;
    f_valid = 1'b0;
    m_req   = 1'b0;
    unique case (state)
      S_IDLE: begin
        f_ready = 1'b1;
        if (f_req && !f_abort) begin
          accept = 1'b1;
          err_n  = base_oob;
          if (base_oob) begin
            state_n = S_RESP;
          end else begin
            state_n = S_RD0;
            addr_n  = base;
          end
        end
      end
      S_RD0: begin
        m_req = 1'b1;
        if (f_abort) begin
          state_n = m_ack ? S_IDLE : S_DRAIN;
        end else if (m_ack) begin
          ld0 = 1'b1;
          if (nw_d == 2'd1) begin
            state_n = S_RESP;
          end else if (inc_oob) begin
            state_n = S_RESP;
            err_n   = 1'b1;
          end else begin
            state_n = S_RD1;
            addr_n  = addr_inc;
          end
        end
      end
      S_RD1: begin
        m_req = 1'b1;
        if (f_abort) begin
          state_n = m_ack ? S_IDLE : S_DRAIN;
        end else if (m_ack) begin
          ld1 = 1'b1;
          if (nw_q == 2'd2) begin
            state_n = S_RESP;
          end else if (inc_oob) begin
            state_n = S_RESP;
            err_n   = 1'b1;
          end else begin
            state_n = S_RD2;
            addr_n  = addr_inc;
          end
        end
      end
      S_RD2: begin
        m_req = 1'b1;
        if (f_abort) begin
          state_n = m_ack ? S_IDLE : S_DRAIN;
        end else if (m_ack) begin
          ld2     = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        f_valid = !f_abort;
        state_n = S_IDLE;
      end
      S_DRAIN: begin
        m_req = 1'b1;
        if (m_ack) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Only byte 16 of the third word can land in a
  // 10-byte window starting at offset 0..7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      len_q  <= '0;
      nw_q   <= '0;
      err_q  <= 1'b0;
      addr_q <= '0;
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
    end else begin
      addr_q <= addr_n;
      err_q  <= err_n;
      if (accept) begin
        off_q <= f_pc[2:0];
        w0_q  <= '0;
        w1_q  <= '0;
        w2_q  <= '0;
      end
      if (ld0) begin
        w0_q  <= m_rdata;
        len_q <= len_d;
        nw_q  <= nw_d;
      end
      if (ld1) begin
        w1_q <= m_rdata;
      end
      if (ld2) begin
        w2_q <= m_rdata[7:0];
      end
    end
  end

  assign win_buf = {w2_q, w1_q, w0_q};
  assign win     = win_buf[{off_q, 3'b000} +: 80];

  always_comb begin
    f_instr = '0;
    if (state == S_RESP && !err_q) begin
      for (int k = 0; k < 10; k++) begin
        if (4'(k) < len_q) begin
          f_instr[8*k +: 8] = win[8*k +: 8];
        end
      end
    end
  end

  assign f_imem_error = f_valid & err_q;
  assign m_addr       = addr_q;

endmodule
